// File: rtl/f_adder_seq.sv
// Sequential nibble-serial adder: one shared 4-bit ripple slice adds
// A+B+cin one nibble per cycle (LSB first). The result is held in DONE
// until the consumer takes it.
module f_adder_seq #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NIB-1:0]  ain,
  input  logic [4*NIB-1:0]  bin,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NIB-1:0]  sout,
  output logic              cout,
  output logic              busy
);

  localparam int W  = 4 * NIB;
  localparam int IW = 3;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q, b_q;
  logic [W-1:0]    sout_q;
  logic            cout_q;

  logic            accept, step, last;
  logic [3:0]      an, bn, nsum;
  logic            c1, c2, c3, c4;

  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  // Select the operand nibbles addressed by idx (constant selects per nibble).
  always_comb begin
    an = '0;
    bn = '0;
    for (int unsigned n = 0; n < NIB; n++) begin
      if (idx == IW'(n)) begin
        an = a_q[4*n +: 4];
        bn = b_q[4*n +: 4];
      end
    end
  end

  // Shared 4-bit ripple slice built from four full adders.
  assign {c1, nsum[0]} = fa(an[0], bn[0], carry);
  assign {c2, nsum[1]} = fa(an[1], bn[1], c1);
  assign {c3, nsum[2]} = fa(an[2], bn[2], c2);
  assign {c4, nsum[3]} = fa(an[3], bn[3], c3);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; clr overrides accept and handoff.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    step     = 1'b0;
    last     = (idx == LAST);
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
        CALC: begin
          step = 1'b1;
          if (last) state_nx = DONE;
        end
        DONE: if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand capture, nibble write-back, carry chaining and index stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sout_q <= '0;
      cout_q <= 1'b0;
    end else if (clr) begin
      idx    <= '0;
      carry  <= 1'b0;
      sout_q <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_q   <= ain;
      b_q   <= bin;
      carry <= cin;
      idx   <= '0;
    end else if (step) begin
      for (int unsigned n = 0; n < NIB; n++) begin
        if (idx == IW'(n)) sout_q[4*n +: 4] <= nsum;
      end
      carry <= c4;
      if (last) begin
        cout_q <= c4;
        idx    <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sout      = sout_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_f_adder_seq.sv
// Directed bench for f_adder_seq: NIB=4 main instance plus NIB=2 and NIB=8.
module tb_f_adder_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // NIB=4
  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [15:0] ain = '0, bin = '0;
  logic        in_ready, out_valid, cout, busy;
  logic [15:0] sout;

  // NIB=2
  logic        in_valid2 = 1'b0, out_ready2 = 1'b0, cin2 = 1'b0;
  logic [7:0]  ain2 = '0, bin2 = '0;
  logic        in_ready2, out_valid2, cout2, busy2;
  logic [7:0]  sout2;

  // NIB=8
  logic        in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
  logic [31:0] ain8 = '0, bin8 = '0;
  logic        in_ready8, out_valid8, cout8, busy8;
  logic [31:0] sout8;

  int vectors = 0;
  int errs = 0;

  f_adder_seq #(.NIB(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .ain(ain), .bin(bin), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sout(sout), .cout(cout), .busy(busy));

  f_adder_seq #(.NIB(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid2), .in_ready(in_ready2),
    .ain(ain2), .bin(bin2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sout(sout2), .cout(cout2), .busy(busy2));

  f_adder_seq #(.NIB(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid8), .in_ready(in_ready8),
    .ain(ain8), .bin(bin8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sout(sout8), .cout(cout8), .busy(busy8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags of the NIB=4 instance packed as {in_ready,out_valid,busy}.
  function automatic logic [2:0] flags4();
    return {in_ready, out_valid, busy};
  endfunction

  initial begin
    // Reset held: outputs zero, in_ready high.
    #12;
    chk("rst_flags", flags4(), 3'b100);
    chk("rst_sout", sout, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    tick();
    chk("rst_hold_flags", flags4(), 3'b100);
    rst_n = 1'b1;

    // 0x1234 + 0x4321 + 0 = 0x5555, 4-cycle latency, operands frozen.
    in_valid = 1'b1; ain = 16'h1234; bin = 16'h4321; cin = 1'b0;
    tick();                                   // E0 accept
    in_valid = 1'b0; ain = 16'hFFFF; bin = 16'hFFFF; cin = 1'b1;
    chk("acc_flags", flags4(), 3'b001);
    tick();                                   // E1
    chk("partial_sout", sout, 16'h0005);
    tick(); tick();                           // E2, E3
    chk("lat_e3_ov", out_valid, 1'b0);
    tick();                                   // E4
    chk("lat_e4_flags", flags4(), 3'b011);
    chk("sum1_sout", sout, 16'h5555);
    chk("sum1_cout", cout, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("handoff_flags", flags4(), 3'b100);
    chk("idle_hold_sout", sout, 16'h5555);

    // 0xFFFF + 0x0000 + 1: carry ripples through every nibble.
    in_valid = 1'b1; ain = 16'hFFFF; bin = 16'h0000; cin = 1'b1;
    tick();
    ain = 16'h1111; bin = 16'h1111; cin = 1'b0; // stays valid: must be ignored
    tick(); tick(); tick(); tick();
    chk("ripple_sout", sout, 16'h0000);
    chk("ripple_cout", cout, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("done_hold_flags", flags4(), 3'b011);
      chk("done_hold_sout", {cout, sout}, 17'h10000);
    end
    out_ready = 1'b1;
    tick();                                   // handoff, no accept this edge
    out_ready = 1'b0;
    chk("no_same_cycle_accept", flags4(), 3'b100);
    tick();                                   // in_valid still high: accept 0x1111+0x1111
    in_valid = 1'b0;
    chk("reaccept_busy", busy, 1'b1);
    tick(); tick(); tick(); tick();
    chk("reaccept_sum", {out_valid, cout, sout}, 18'h22222);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // clr at the CALC edge processing idx=2.
    in_valid = 1'b1; ain = 16'hABCD; bin = 16'h1111; cin = 1'b0;
    tick();                                   // E0
    in_valid = 1'b0;
    tick(); tick();                           // idx0, idx1 done
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_flags", flags4(), 3'b100);
    chk("clr_sout", {cout, sout}, 17'h00000);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_no_ov", out_valid, 1'b0);
    end
    in_valid = 1'b1; ain = 16'h00FF; bin = 16'h0001; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("after_clr_sum", {out_valid, cout, sout}, 18'h20100);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Async reset mid-CALC between edges.
    in_valid = 1'b1; ain = 16'h8888; bin = 16'h8888; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();                                   // sout = 0x0100 with nibble0 rewritten to 0
    chk("pre_rst_sout", sout, 16'h0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sout", {cout, sout}, 17'h00000);
    chk("async_rst_flags", flags4(), 3'b100);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_ov", flags4(), 3'b100);
    end

    // Overflow wraps: 0xFFFF + 0xFFFF + 1 = 0x1FFFF.
    in_valid = 1'b1; ain = 16'hFFFF; bin = 16'hFFFF; cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("overflow", {out_valid, cout, sout}, 18'h3FFFF);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // NIB=2: 0xF0 + 0x1F = 0x10F, two-cycle latency.
    in_valid2 = 1'b1; ain2 = 8'hF0; bin2 = 8'h1F; cin2 = 1'b0;
    tick();
    in_valid2 = 1'b0;
    tick();
    chk("n2_lat", out_valid2, 1'b0);
    tick();
    chk("n2_sum1", {out_valid2, cout2, sout2}, 10'h30F);
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;
    in_valid2 = 1'b1; ain2 = 8'h7F; bin2 = 8'h01; cin2 = 1'b0;
    tick();
    in_valid2 = 1'b0;
    tick(); tick();
    chk("n2_sum2", {out_valid2, cout2, sout2}, 10'h280);
    out_ready2 = 1'b1; tick(); out_ready2 = 1'b0;

    // NIB=8: 0x89ABCDEF + 0x76543210 + 1 = 0x1_00000000.
    in_valid8 = 1'b1; ain8 = 32'h89ABCDEF; bin8 = 32'h76543210; cin8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("n8_lat", out_valid8, 1'b0);
    tick();
    chk("n8_sum", {out_valid8, cout8, sout8}, 34'h3_0000_0000 & 34'h3_0000_0000);
    chk("n8_sout", sout8, 32'h0000_0000);
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
    in_valid8 = 1'b1; ain8 = 32'h1234_5678; bin8 = 32'h1111_1111; cin8 = 1'b0;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("n8_sum2", {out_valid8, cout8, sout8}, {2'b10, 32'h2345_6789});
    out_ready8 = 1'b1; tick(); out_ready8 = 1'b0;
    chk("n8_idle", {in_ready8, busy8}, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
